// File: rtl/mem_copy_dma.sv
// Byte-serial block-copy bus master: read-then-write per byte over a single-port
// memory bus, with an 8-bit running checksum of every byte moved.
module mem_copy_dma #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] src_nx;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] dst_nx;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  rem_nx;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_nx;
    logic [DATA_W-1:0] csum_nx;
    logic              busy_nx;
    logic              done_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;

    // State, datapath and registered bus/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_reg  <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            state     <= state_nx;
            src_ptr   <= src_nx;
            dst_ptr   <= dst_nx;
            remaining <= rem_nx;
            data_reg  <= data_nx;
            checksum  <= csum_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            bus_we    <= we_nx;
            bus_addr  <= addr_nx;
            bus_wdata <= wdata_nx;
        end
    end

    // Next-state/datapath logic; outputs are decoded from the next state so the
    // registered bus lines line up with the state they belong to
    always_comb begin
        state_nx = state;
        src_nx   = src_ptr;
        dst_nx   = dst_ptr;
        rem_nx   = remaining;
        data_nx  = data_reg;
        csum_nx  = checksum;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        we_nx    = 1'b0;
        addr_nx  = bus_addr;
        wdata_nx = data_reg;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    src_nx   = src_addr;
                    dst_nx   = dst_addr;
                    rem_nx   = len;
                    csum_nx  = '0;
                    state_nx = (len != '0) ? S_RD : S_DONE;
                end
            end
            S_RD: begin
                state_nx = S_CAP;
            end
            S_CAP: begin
                data_nx  = bus_rdata;
                csum_nx  = checksum + bus_rdata;
                state_nx = S_WR;
            end
            S_WR: begin
                src_nx   = src_ptr + ADDR_W'(1);
                dst_nx   = dst_ptr + ADDR_W'(1);
                rem_nx   = remaining - LEN_W'(1);
                state_nx = (remaining == LEN_W'(1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        unique case (state_nx)
            S_RD, S_CAP: begin
                busy_nx = 1'b1;
                addr_nx = src_nx;
            end
            S_WR: begin
                busy_nx = 1'b1;
                we_nx   = 1'b1;
                addr_nx = dst_nx;
            end
            S_DONE: begin
                done_nx = 1'b1;
            end
            default: begin
                busy_nx = 1'b0;
            end
        endcase

        wdata_nx = data_nx;
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomized self-checking bench for mem_copy_dma: bus-level RAM, a transfer-level
// copy model, a per-cycle compare process and directed literal scenarios.
module tb_mem_copy_dma;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    mem_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .checksum (checksum),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus RAM: registered read, write at the end of a bus_we cycle
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];
    always @(posedge clk) begin
        bus_rdata <= ram[bus_addr];
        if (bus_we) ram[bus_addr] <= bus_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transfer descriptor and expected results
    bit         chk_en    = 1'b0;
    bit         have_xfer = 1'b0;
    int         t0        = 0;
    logic [15:0] x_src, x_dst;
    int         x_len     = 0;
    logic [7:0] exp_bytes [$];
    logic [7:0] exp_sum   = 8'h00;
    logic [7:0] prev_sum  = 8'h00;

    int busy_cnt      = 0;
    int we_cnt        = 0;
    int last_done_cyc = -1;

    int          r, bi, ph;
    logic [15:0] ea;
    always @(negedge clk) begin
        if (chk_en) begin
            if (busy) busy_cnt++;
            if (bus_we) we_cnt++;
            if (done) last_done_cyc = cyc;
            r = cyc - t0;
            if (have_xfer && r >= 1 && r <= 3 * x_len) begin
                bi = (r - 1) / 3;
                ph = (r - 1) % 3;
                ea = (ph == 2) ? x_dst + 16'(bi) : x_src + 16'(bi);
                check("busy", 32'(busy), 32'd1);
                check("done", 32'(done), 32'd0);
                check("bus_we", 32'(bus_we), 32'(ph == 2));
                check("bus_addr", 32'(bus_addr), 32'(ea));
                if (ph == 2) check("bus_wdata", 32'(bus_wdata), 32'(exp_bytes[bi]));
            end else begin
                check("busy_idle", 32'(busy), 32'd0);
                check("bus_we_idle", 32'(bus_we), 32'd0);
                if (have_xfer && r == 3 * x_len + 1) begin
                    check("done_pulse", 32'(done), 32'd1);
                end else begin
                    check("done_idle", 32'(done), 32'd0);
                end
                if (have_xfer && r >= 1) check("checksum", 32'(checksum), 32'(exp_sum));
                else check("checksum_hold", 32'(checksum), 32'(prev_sum));
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // Forward byte-by-byte copy on the reference memory
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        exp_bytes.delete();
        exp_sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = ref_mem[s + 16'(i)];
            exp_bytes.push_back(b);
            ref_mem[d + 16'(i)] = b;
            exp_sum = exp_sum + b;
        end
    endtask

    int busy_base, we_base;

    task automatic begin_xfer(input logic [15:0] s, input logic [15:0] d, input int n);
        @(posedge clk);
        #1;
        prev_sum  = have_xfer ? exp_sum : prev_sum;
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = d;
        len       = 16'(n);
        t0        = cyc;
        x_src     = s;
        x_dst     = d;
        x_len     = n;
        model_copy(s, d, n);
        have_xfer = 1'b1;
        busy_base = busy_cnt;
        we_base   = we_cnt;
    endtask

    // Runs one transfer to its done cycle; hz>0 pulses a stray start in that cycle
    task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input int n, input int hz);
        int bad;
        begin_xfer(s, d, n);
        for (int k = 1; k <= 3 * n + 1; k++) begin
            @(posedge clk);
            #1;
            start    = (k == hz);
            src_addr = 16'($urandom);
            dst_addr = 16'($urandom);
            len      = 16'($urandom_range(1, 5));
        end
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (ram[d + 16'(i)] !== ref_mem[d + 16'(i)]) bad++;
        if (n > 0) check("mem_copy", 32'(bad), 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic run_abort(input logic [15:0] s, input logic [15:0] d);
        logic [7:0] old1, old2;
        old1 = ref_mem[d + 16'd1];
        old2 = ref_mem[d + 16'd2];
        begin_xfer(s, d, 3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        have_xfer = 1'b0;
        prev_sum  = 8'h00;
        ref_mem[d + 16'd1] = old1;
        ref_mem[d + 16'd2] = old2;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(bus_we), 32'd0);
        check("abort_checksum", 32'(checksum), 32'd0);
        check("abort_first_byte", 32'(ram[d]), 32'(ref_mem[d]));
        check("abort_second_byte", 32'(ram[d + 16'd1]), 32'(old1));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int a = 0; a < 65536; a++) begin
            ram[a]     = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_wdata", 32'(bus_wdata), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        we_base = we_cnt;
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_writes", 32'(we_cnt - we_base), 32'd0);

        // Basic three-byte copy
        poke(16'h0010, 8'h11);
        poke(16'h0011, 8'h22);
        poke(16'h0012, 8'h33);
        run_xfer(16'h0010, 16'h0400, 3, 0);
        check("basic_done_cycle", 32'(last_done_cyc - t0), 32'd10);
        check("basic_we_cycles", 32'(we_cnt - we_base), 32'd3);
        check("basic_checksum", 32'(checksum), 32'h66);
        check("basic_mem0", 32'(ram[16'h0400]), 32'h11);
        check("basic_mem1", 32'(ram[16'h0401]), 32'h22);
        check("basic_mem2", 32'(ram[16'h0402]), 32'h33);

        // Stray start at cycle 4 is ignored
        run_xfer(16'h0010, 16'h0410, 3, 4);
        check("stray_start_done_cycle", 32'(last_done_cyc - t0), 32'd10);
        check("stray_start_checksum", 32'(checksum), 32'h66);

        // Zero-length transfer
        run_xfer(16'h2000, 16'h3000, 0, 0);
        check("len0_done_cycle", 32'(last_done_cyc - t0), 32'd1);
        check("len0_busy", 32'(busy_cnt - busy_base), 32'd0);
        check("len0_writes", 32'(we_cnt - we_base), 32'd0);
        check("len0_checksum", 32'(checksum), 32'd0);

        // Source pointer wraps past 0xFFFF
        poke(16'hFFFF, 8'hAA);
        poke(16'h0000, 8'h55);
        run_xfer(16'hFFFF, 16'h0800, 2, 0);
        check("wrap_checksum", 32'(checksum), 32'hFF);
        check("wrap_mem0", 32'(ram[16'h0800]), 32'hAA);
        check("wrap_mem1", 32'(ram[16'h0801]), 32'h55);

        // Overlapping forward copy smears the first byte
        poke(16'h0100, 8'h7E);
        run_xfer(16'h0100, 16'h0101, 3, 0);
        check("overlap_mem1", 32'(ram[16'h0101]), 32'h7E);
        check("overlap_mem2", 32'(ram[16'h0102]), 32'h7E);
        check("overlap_mem3", 32'(ram[16'h0103]), 32'h7E);

        // Reset mid-transfer, then a fresh transfer
        poke(16'h0500, 8'h01);
        poke(16'h0501, 8'h02);
        poke(16'h0502, 8'h03);
        run_abort(16'h0500, 16'h0600);
        run_xfer(16'h0010, 16'h0700, 3, 0);
        check("after_abort_done_cycle", 32'(last_done_cyc - t0), 32'd10);
        check("after_abort_checksum", 32'(checksum), 32'h66);

        // Random transfers, some back-to-back, some overlapping or wrapping
        for (int t = 0; t < 40; t++) begin
            logic [15:0] s, d;
            int n;
            n = $urandom_range(0, 9);
            s = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s = 16'hFFFF - 16'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) d = s + 16'($urandom_range(0, 4));
            else d = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_xfer(s, d, n, (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * n) : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
